// File: rtl/cross_phase_ctrl_pkg.sv
// Shared definitions for the cross-street phase controller: state encoding,
// last-served encoding and a timed-state helper.
package cross_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEC_GRN   = 3'd1,
        SEC_YEL   = 3'd2,
        PED_WALK  = 3'd3,
        PED_FLASH = 3'd4,
        DONE      = 3'd5
    } state_e;

    localparam logic LAST_SEC = 1'b1;
    localparam logic LAST_PED = 1'b0;

    function automatic logic is_timed(input state_e s);
        return (s == SEC_GRN) || (s == SEC_YEL) || (s == PED_WALK) || (s == PED_FLASH);
    endfunction

endpackage

// File: rtl/cross_phase_ctrl_if.sv
// Request/grant handshake and lamp bundle between the highway side (master)
// and the cross-street phase controller (slave).
interface cross_phase_ctrl_if;
    logic S;
    logic P;
    logic hwy_red;
    logic req;
    logic sec_green;
    logic sec_yellow;
    logic ped_walk;
    logic ped_flash;
    logic done;
    logic Q;

    modport master (
        output S, P, hwy_red,
        input  req, sec_green, sec_yellow, ped_walk, ped_flash, done, Q
    );

    modport slave (
        input  S, P, hwy_red,
        output req, sec_green, sec_yellow, ped_walk, ped_flash, done, Q
    );
endinterface

// File: rtl/cross_phase_ctrl_phase_timer.sv
// Loadable down-counter that times each lamp phase; holds at zero once expired.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_value,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);
endmodule

// File: rtl/cross_phase_ctrl.sv
// Cross-street phase controller: latches S/P requests, serves one per highway red grant.
// Optional macro CROSS_PED_FLASH_EN adds the flashing don't-walk phase.
module cross_phase_ctrl
    import cross_pkg::*;
#(
    parameter int unsigned SEC_GREEN_CYC  = 8,
    parameter int unsigned SEC_YELLOW_CYC = 4,
    parameter int unsigned PED_WALK_CYC   = 8,
    parameter int unsigned PED_FLASH_CYC  = 4,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    cross_phase_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] LD_GRN   = CNT_W'(SEC_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_YEL   = CNT_W'(SEC_YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] LD_WALK  = CNT_W'(PED_WALK_CYC - 1);
    localparam logic [CNT_W-1:0] LD_FLASH = CNT_W'(PED_FLASH_CYC - 1);

    state_e           r_state;
    state_e           w_next;
    logic             r_pend_s;
    logic             r_pend_p;
    logic             r_req;
    logic             r_q;
    logic             w_load;
    logic             w_zero;
    logic             w_clr_s;
    logic             w_clr_p;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cur_max;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .i_clk      (Clock),
        .i_rst_n    (Resetn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_value    (w_cnt),
        .o_zero     (w_zero)
    );

    // With both requests pending, the side not served last time wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.hwy_red) begin
                    if (r_pend_s && (!r_pend_p || r_q == LAST_PED))
                        w_next = SEC_GRN;
                    else if (r_pend_p)
                        w_next = PED_WALK;
                    else
                        w_next = DONE;
                end
            end
            SEC_GRN:   if (!bus.hwy_red) w_next = IDLE; else if (w_zero) w_next = SEC_YEL;
            SEC_YEL:   if (!bus.hwy_red) w_next = IDLE; else if (w_zero) w_next = DONE;
`ifdef CROSS_PED_FLASH_EN
            PED_WALK:  if (!bus.hwy_red) w_next = IDLE; else if (w_zero) w_next = PED_FLASH;
`else
            PED_WALK:  if (!bus.hwy_red) w_next = IDLE; else if (w_zero) w_next = DONE;
`endif
            PED_FLASH: if (!bus.hwy_red) w_next = IDLE; else if (w_zero) w_next = DONE;
            DONE:      if (!bus.hwy_red) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load     = (w_next != r_state) && is_timed(w_next);
        w_load_val = '0;
        case (w_next)
            SEC_GRN:   w_load_val = LD_GRN;
            SEC_YEL:   w_load_val = LD_YEL;
            PED_WALK:  w_load_val = LD_WALK;
            PED_FLASH: w_load_val = LD_FLASH;
            default:   w_load_val = '0;
        endcase
    end

    assign w_clr_s = (r_state == IDLE) && (w_next == SEC_GRN);
    assign w_clr_p = (r_state == IDLE) && (w_next == PED_WALK);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= IDLE;
            r_pend_s <= 1'b0;
            r_pend_p <= 1'b0;
            r_req    <= 1'b0;
            r_q      <= LAST_PED;
        end else begin
            r_state  <= w_next;
            r_pend_s <= bus.S | (r_pend_s & ~w_clr_s);
            r_pend_p <= bus.P | (r_pend_p & ~w_clr_p);
            r_req    <= r_pend_s | r_pend_p;
            if (w_clr_s)
                r_q <= LAST_SEC;
            else if (w_clr_p)
                r_q <= LAST_PED;
        end
    end

    assign bus.req        = r_req;
    assign bus.Q          = r_q;
    assign bus.sec_green  = (r_state == SEC_GRN);
    assign bus.sec_yellow = (r_state == SEC_YEL);
    assign bus.ped_walk   = (r_state == PED_WALK);
`ifdef CROSS_PED_FLASH_EN
    assign bus.ped_flash  = (r_state == PED_FLASH);
`else
    assign bus.ped_flash  = 1'b0;
`endif
    assign bus.done       = (r_state == DONE);

    always_comb begin
        w_cur_max = '1;
        case (r_state)
            SEC_GRN:   w_cur_max = LD_GRN;
            SEC_YEL:   w_cur_max = LD_YEL;
            PED_WALK:  w_cur_max = LD_WALK;
            PED_FLASH: w_cur_max = LD_FLASH;
            default:   w_cur_max = '1;
        endcase
    end

    // A running phase never holds more time than it was loaded with.
    a_cnt_in_range: assert property (@(posedge Clock) disable iff (!Resetn)
        w_cnt <= w_cur_max);
endmodule

// File: tb/tb_cross_phase_ctrl.sv
// Self-checking bench for cross_phase_ctrl: directed scenarios then random traffic,
// checked against a time-indexed service model.
module tb_cross_phase_ctrl;
    import cross_pkg::*;

    localparam int unsigned G = 8;
    localparam int unsigned Y = 4;
    localparam int unsigned W = 8;
    localparam int unsigned F = 4;
`ifdef CROSS_PED_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif
    localparam int unsigned SEC_T = G + Y;
    localparam int unsigned PED_T = FLASH ? (W + F) : W;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    cross_phase_ctrl_if bus();

    cross_phase_ctrl #(
        .SEC_GREEN_CYC  (G),
        .SEC_YELLOW_CYC (Y),
        .PED_WALK_CYC   (W),
        .PED_FLASH_CYC  (F),
        .CNT_W          (8)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    // Model: pending flags, last-served, and the active service as kind + cycle index.
    bit          m_pend_s, m_pend_p, m_req, m_q, m_busy, m_done;
    int          m_kind;   // 0 = secondary, 1 = pedestrian
    int unsigned m_t;

    int n_checks = 0;
    int n_errors = 0;
    int obs_g, obs_y, obs_w, obs_f;
    bit rs, rp, rh;

    function automatic void model_reset();
        m_pend_s = 0; m_pend_p = 0; m_req = 0; m_q = 0;
        m_busy = 0; m_done = 0; m_kind = 0; m_t = 0;
    endfunction

    task automatic model_edge(input bit s, input bit p, input bit h);
        bit old_s = m_pend_s;
        bit old_p = m_pend_p;
        bit clr_s = 0;
        bit clr_p = 0;
        if (m_busy) begin
            if (!h) m_busy = 0;
            else begin
                m_t++;
                if (m_t == ((m_kind == 0) ? SEC_T : PED_T)) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (m_done) begin
            if (!h) m_done = 0;
        end else if (h) begin
            if (old_s && (!old_p || !m_q)) begin
                m_kind = 0; clr_s = 1; m_q = 1; m_busy = 1; m_t = 0;
            end else if (old_p) begin
                m_kind = 1; clr_p = 1; m_q = 0; m_busy = 1; m_t = 0;
            end else begin
                m_done = 1;
            end
        end
        m_req    = old_s | old_p;
        m_pend_s = s | (old_s & !clr_s);
        m_pend_p = p | (old_p & !clr_p);
    endtask

    function automatic logic [6:0] model_out();
        logic g, yl, wk, fl;
        g  = m_busy && (m_kind == 0) && (m_t < G);
        yl = m_busy && (m_kind == 0) && (m_t >= G);
        wk = m_busy && (m_kind == 1) && (m_t < W);
        fl = m_busy && (m_kind == 1) && (m_t >= W);
        return {m_req, g, yl, wk, fl, m_done, m_q};
    endfunction

    task automatic check(input string tag);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {bus.req, bus.sec_green, bus.sec_yellow, bus.ped_walk,
               bus.ped_flash, bus.done, bus.Q};
        exp = model_out();
        obs_g += int'(bus.sec_green);
        obs_y += int'(bus.sec_yellow);
        obs_w += int'(bus.ped_walk);
        obs_f += int'(bus.ped_flash);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s {req,sg,sy,pw,pf,done,Q} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit p, input bit h, input string tag);
        bus.S = s; bus.P = p; bus.hwy_red = h;
        @(posedge Clock);
        model_edge(s, p, h);
        #1;
        check(tag);
    endtask

    task automatic cyc_n(input bit s, input bit p, input bit h, input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(s, p, h, tag);
    endtask

    task automatic clear_counts();
        obs_g = 0; obs_y = 0; obs_w = 0; obs_f = 0;
    endtask

    task automatic async_reset(input string tag);
        #2 Resetn = 1'b0;
        model_reset();
        #1 check(tag);
        @(posedge Clock);
        #1 Resetn = 1'b1;
    endtask

    initial begin
        bus.S = 0; bus.P = 0; bus.hwy_red = 0;
        model_reset();
        clear_counts();
        #12 check("reset_state");
        @(posedge Clock);
        #1 Resetn = 1'b1;

        // Secondary service from a single-cycle S pulse.
        cyc(1, 0, 0, "s_pulse");
        cyc(0, 0, 0, "req_rise");
        clear_counts();
        cyc_n(0, 0, 1, SEC_T + 1, "sec_service");
        check_int("sec_green_len", obs_g, G);
        check_int("sec_yellow_len", obs_y, Y);
        check_int("q_after_sec", int'(bus.Q), int'(LAST_SEC));
        cyc(0, 0, 0, "sec_release");
        cyc(0, 0, 0, "sec_idle");

        // Both pending: secondary first, then pedestrian on the next grant.
        model_reset();
        Resetn = 1'b0;
        #1 check("reset_again");
        @(posedge Clock);
        #1 Resetn = 1'b1;
        cyc(1, 1, 0, "both_pulse");
        cyc(0, 0, 0, "both_req");
        cyc_n(0, 0, 1, SEC_T + 1, "both_sec");
        cyc(0, 0, 0, "both_release");
        clear_counts();
        cyc_n(0, 0, 1, PED_T + 1, "both_ped");
        check_int("walk_len", obs_w, W);
        check_int("flash_len", obs_f, FLASH ? F : 0);
        check_int("q_after_ped", int'(bus.Q), int'(LAST_PED));
        cyc(0, 0, 0, "ped_release");

        // Grant with nothing pending.
        clear_counts();
        cyc(0, 0, 1, "empty_grant");
        cyc(0, 0, 1, "empty_hold");
        cyc(0, 0, 0, "empty_release");
        check_int("empty_no_lamp", obs_g + obs_y + obs_w + obs_f, 0);

        // Abort on cycle 3 of green.
        cyc(1, 0, 0, "abort_req");
        cyc(0, 0, 0, "abort_req2");
        cyc_n(0, 0, 1, 3, "abort_green");
        cyc(0, 0, 0, "abort_edge");
        cyc(0, 0, 0, "abort_after");

        // S held through a whole service, then P joins.
        cyc(1, 0, 0, "hold_s");
        cyc(1, 0, 0, "hold_s_req");
        cyc_n(1, 0, 1, SEC_T + 1, "hold_service");
        cyc(1, 1, 0, "hold_release");
        cyc(0, 0, 0, "hold_idle");
        cyc_n(0, 0, 1, 3, "hold_next_ped");
        cyc(0, 0, 0, "hold_abort");

        // Asynchronous reset during walk.
        cyc(0, 1, 0, "rst_p");
        cyc(0, 0, 0, "rst_p_req");
        cyc_n(0, 0, 1, 3, "rst_walk");
        async_reset("async_rst_walk");
        cyc(0, 1, 0, "post_rst_p");
        cyc(0, 0, 0, "post_rst_req");
        clear_counts();
        cyc_n(0, 0, 1, PED_T + 1, "post_rst_ped");
        check_int("post_rst_walk_len", obs_w, W);
        cyc(0, 0, 0, "post_rst_release");

        // Random traffic with occasional mid-cycle resets.
        rh = 0;
        for (int i = 0; i < 800; i++) begin
            rs = ($urandom_range(0, 5) == 0);
            rp = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) rh = !rh;
            cyc(rs, rp, rh, "random");
            if ($urandom_range(0, 249) == 0) async_reset("random_rst");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cross_phase_ctrl.md
# cross_phase_ctrl

Cross-street phase controller for the lab9 intersection: the responder side of the highway controller's request/red handshake. It latches secondary-road (S) and pedestrian (P) requests, serves one of them while the highway holds red, and signals completion. When both requests are pending it alternates fairness with a last-served toggle.

## Interface
- SEC_GREEN_CYC, default 8: secondary green duration, in cycles (≥1).
- SEC_YELLOW_CYC, default 4: secondary yellow duration, in cycles (≥1).
- PED_WALK_CYC, default 8: pedestrian walk duration, in cycles (≥1).
- PED_FLASH_CYC, default 4: flashing don't-walk duration, in cycles (≥1).
- CNT_W, default 8: phase counter width; every *_CYC must be ≤ 2^CNT_W.
- Clock  input  1  single clock; all state changes on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- S  input  1  secondary-road sensor, level, sampled each cycle.
- P  input  1  pedestrian button, level, sampled each cycle.
- hwy_red  input  1  from the highway controller; 1 = highway holding red (grant).
- req  output  1  registered OR of the pending latches; this is the highway controller's request input.
- sec_green, sec_yellow  output  1 each  secondary-road lamps.
- ped_walk, ped_flash  output  1 each  pedestrian lamps.
- done  output  1  service complete; a level held until hwy_red falls.
- Q  output  1  last served: 1 = secondary, 0 = pedestrian.

## Operation
- Pending latches pend_s and pend_p. A latch is set when its input is 1 in any cycle. It is cleared on the cycle its service phase is entered.
- If an input is high on the same edge that its latch clears, the latch stays set, so that request is served next round.
- States: IDLE, SEC_GRN, SEC_YEL, PED_WALK, PED_FLASH, DONE.
- Transitions out of IDLE, when hwy_red=1:
  - Only pend_s set: go to SEC_GRN.
  - Only pend_p set: go to PED_WALK.
  - Both set: if Q=1 go to PED_WALK, else go to SEC_GRN.
  - Neither set: go straight to DONE.
- Phase sequences:
  - SEC_GRN, then SEC_YEL, then DONE.
  - PED_WALK, then PED_FLASH, then DONE.
- Q is updated on entry to a service: 1 on entry to SEC_GRN, 0 on entry to PED_WALK.
- DONE: done=1; stay until hwy_red=0, then go to IDLE.
- Abort: if hwy_red falls in any service state, go to IDLE on the next edge.
  - All lamps go off at that edge.
  - The request being served is not re-latched unless its input is still asserted.
  - Q keeps its updated value.
- Outputs are decoded from the state register, so there is no combinational path from inputs to outputs.
  - sec_green is 1 only in SEC_GRN; sec_yellow only in SEC_YEL; ped_walk only in PED_WALK; ped_flash only in PED_FLASH; done only in DONE.

## Timing
- Reset values: state=IDLE, pend_s=pend_p=0, req=0, Q=0, counter=0, all lamps and done=0.
- Phase counter:
  - Loaded with N−1 on the edge that enters a timed state.
  - Decrements each cycle; the state advances on the edge where the counter is 0.
  - Each timed state therefore lasts exactly N cycles, and N=1 gives one cycle.
- Request latency: S high at edge k gives pend_s=1 after edge k, and req=1 after edge k+1.
- Grant latency: hwy_red sampled 1 in IDLE at edge k puts the first lamp on after edge k.
- Secondary service: hwy_red high to done high is SEC_GREEN_CYC+SEC_YELLOW_CYC cycles.
- Pedestrian service: the same, using PED_WALK_CYC+PED_FLASH_CYC.
- hwy_red falling while in DONE returns the block to IDLE one edge later.
- A new service needs a fresh rising hwy_red in IDLE.
- Reset asserted mid-phase clears everything immediately (asynchronously). No lamp stays lit.

## Configuration
- CROSS_PED_FLASH_EN defined: the PED_FLASH state exists and ped_flash is driven as above.
- CROSS_PED_FLASH_EN undefined:
  - PED_WALK goes directly to DONE, and PED_FLASH_CYC is unused.
  - ped_flash is tied to 0.
  - Pedestrian service time is PED_WALK_CYC.

## Structure
- Shared package cross_pkg holds:
  - the state enum (3-bit encoding: IDLE=0, SEC_GRN=1, SEC_YEL=2, PED_WALK=3, PED_FLASH=4, DONE=5);
  - the Q encoding constants LAST_SEC=1 and LAST_PED=0.
- One sub-module, phase_timer: a loadable down-counter with CNT_W width, and load, value and zero-flag ports. The FSM and the latches live in the top module.

## Test plan
- Reset, then S pulsed for one cycle, then hwy_red=1 held → req=1; sec_green high for 8 cycles, then sec_yellow for 4, then done=1; Q=1; req=0 afterwards.
- S and P both pending after reset (Q=0), hwy_red=1 → secondary served first, Q=1. Deassert and reassert hwy_red → pedestrian served: ped_walk 8 cycles, ped_flash 4 cycles, then Q=0.
- hwy_red=1 with no pending request → done=1 one edge later; no lamp asserts. hwy_red=0 → IDLE.
- hwy_red drops on cycle 3 of SEC_GRN → all lamps 0 after the next edge, state IDLE, pend_s=0 if S is already low.
- S held high through an entire secondary service → pend_s=1 at DONE and req stays 1. Next grant serves P if it is pending, else S.
- Resetn pulsed low during PED_WALK → outputs 0 immediately without a clock edge; Q=0. With CROSS_PED_FLASH_EN undefined, done follows 8 cycles of walk.
